// File: rtl/ldm_stm_pkg.sv
// Shared definitions for the LDM/STM sequencers: FSM state encoding,
// addressing-mode constants ({P,U}) and the transfer word size.
package ldm_stm_pkg;

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } state_t;

    localparam logic [1:0] IA = 2'b01;
    localparam logic [1:0] IB = 2'b11;
    localparam logic [1:0] DA = 2'b00;
    localparam logic [1:0] DB = 2'b10;

    localparam int WORD_BYTES = 4;

endpackage

// File: rtl/ldm_stm_mem_addr_gen_popcount16.sv
// Combinational population count of a 16-bit register list (0..16).
module popcount16 (
    input  logic [15:0] data,
    output logic [4:0]  count
);

    // Ripple sum of the set bits.
    always_comb begin
        count = 5'd0;
        for (int i = 0; i < 16; i++) begin
            count = count + {4'd0, data[i]};
        end
    end

endmodule

// File: rtl/ldm_stm_mem_addr_gen.sv
// Memory-side LDM/STM sequencer: turns upstream register beats into ascending
// word-aligned (register, address) transfers plus a base writeback pulse.
module ldm_stm_mem_addr_gen
    import ldm_stm_pkg::*;
#(
    parameter int ADDR_W = 32,
    parameter int LIST_W = 16
) (
    input  logic              clk_in,
    input  logic              reset_in,
    input  logic              ldm_stm_start_in,
    input  logic [LIST_W-1:0] data_in,
    input  logic [ADDR_W-1:0] base_addr_in,
    input  logic              p_in,
    input  logic              u_in,
    input  logic              w_in,
    input  logic [3:0]        reg_addr_in,
    input  logic              ldm_stm_en_in,
    output logic [3:0]        reg_addr_out,
    output logic [ADDR_W-1:0] mem_addr_out,
    output logic              mem_valid_out,
    output logic              busy_out,
    output logic              done_out,
    output logic              wb_en_out,
    output logic [ADDR_W-1:0] wb_data_out
);

    localparam logic [ADDR_W-1:0] STEP = ADDR_W'(WORD_BYTES);

    state_t            state_r, state_s;
    logic [ADDR_W-1:0] cur_r, cur_s;
    logic [ADDR_W-1:0] wb_r, wb_s;
    logic [4:0]        n_r, n_s;
    logic [4:0]        cnt_r, cnt_s;
    logic              w_r, w_s;

    logic [3:0]        reg_out_r, reg_out_s;
    logic [ADDR_W-1:0] mem_out_r, mem_out_s;
    logic              valid_r, valid_s;
    logic              busy_r, busy_s;
    logic              done_r, done_s;
    logic              wb_en_r, wb_en_s;
    logic [ADDR_W-1:0] wb_data_r, wb_data_s;

    logic [4:0]        pop_s;
    logic [ADDR_W-1:0] base_al_s;
    logic [ADDR_W-1:0] n4_s;
    logic [ADDR_W-1:0] first_s;
    logic [ADDR_W-1:0] wb_calc_s;

    popcount16 u_popcount (
        .data  (data_in[15:0]),
        .count (pop_s)
    );

    // Start-time address arithmetic: lowest address and writeback value.
    always_comb begin
        base_al_s = {base_addr_in[ADDR_W-1:2], 2'b00};
        n4_s      = {{(ADDR_W-7){1'b0}}, pop_s, 2'b00};
        first_s   = base_al_s;
        case ({p_in, u_in})
            IA:      first_s = base_al_s;
            IB:      first_s = base_al_s + STEP;
            DA:      first_s = base_al_s - n4_s + STEP;
            DB:      first_s = base_al_s - n4_s;
            default: first_s = base_al_s;
        endcase
        if (u_in) begin
            wb_calc_s = base_al_s + n4_s;
        end else begin
            wb_calc_s = base_al_s - n4_s;
        end
    end

    // Next-state and next-output logic; every output is registered below.
    always_comb begin
        state_s   = state_r;
        cur_s     = cur_r;
        wb_s      = wb_r;
        n_s       = n_r;
        cnt_s     = cnt_r;
        w_s       = w_r;
        reg_out_s = 4'd0;
        mem_out_s = '0;
        valid_s   = 1'b0;
        busy_s    = 1'b0;
        done_s    = 1'b0;
        wb_en_s   = 1'b0;
        wb_data_s = '0;
        case (state_r)
            ST_IDLE: begin
                // busy_r high in IDLE means this is the done cycle: no new start yet.
                if (ldm_stm_start_in && !busy_r) begin
                    cur_s  = first_s;
                    wb_s   = wb_calc_s;
                    n_s    = pop_s;
                    cnt_s  = 5'd0;
                    w_s    = w_in;
                    busy_s = 1'b1;
                    if (pop_s == 5'd0) begin
                        done_s    = 1'b1;
                        wb_en_s   = w_in;
                        wb_data_s = base_al_s;
                        state_s   = ST_IDLE;
                    end else begin
                        state_s   = ST_RUN;
                    end
                end else begin
                    state_s = ST_IDLE;
                end
            end
            ST_RUN: begin
                busy_s = 1'b1;
                if (ldm_stm_en_in) begin
                    reg_out_s = reg_addr_in;
                    mem_out_s = cur_r;
                    valid_s   = 1'b1;
                    cur_s     = cur_r + STEP;
                    cnt_s     = cnt_r + 5'd1;
                    if (cnt_r + 5'd1 == n_r) begin
                        done_s    = 1'b1;
                        wb_en_s   = w_r;
                        wb_data_s = wb_r;
                        state_s   = ST_IDLE;
                    end else begin
                        state_s   = ST_RUN;
                    end
                end else begin
                    state_s = ST_RUN;
                end
            end
            default: begin
                state_s = ST_IDLE;
            end
        endcase
    end

    // State, working registers and registered outputs.
    always_ff @(posedge clk_in) begin
        if (reset_in) begin
            state_r   <= ST_IDLE;
            cur_r     <= '0;
            wb_r      <= '0;
            n_r       <= 5'd0;
            cnt_r     <= 5'd0;
            w_r       <= 1'b0;
            reg_out_r <= 4'd0;
            mem_out_r <= '0;
            valid_r   <= 1'b0;
            busy_r    <= 1'b0;
            done_r    <= 1'b0;
            wb_en_r   <= 1'b0;
            wb_data_r <= '0;
        end else begin
            state_r   <= state_s;
            cur_r     <= cur_s;
            wb_r      <= wb_s;
            n_r       <= n_s;
            cnt_r     <= cnt_s;
            w_r       <= w_s;
            reg_out_r <= reg_out_s;
            mem_out_r <= mem_out_s;
            valid_r   <= valid_s;
            busy_r    <= busy_s;
            done_r    <= done_s;
            wb_en_r   <= wb_en_s;
            wb_data_r <= wb_data_s;
        end
    end

    assign reg_addr_out  = reg_out_r;
    assign mem_addr_out  = mem_out_r;
    assign mem_valid_out = valid_r;
    assign busy_out      = busy_r;
    assign done_out      = done_r;
    assign wb_en_out     = wb_en_r;
    assign wb_data_out   = wb_data_r;

endmodule
